// File: rtl/regdst_mux.sv
// regdst_mux: rt/rd destination-register select with registered copy and rd-select counter (optional Link via REGDST_LINK_EN)
module regdst_mux #(
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              RegDst,
`ifdef REGDST_LINK_EN
  input  logic              Link,
`endif
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [ADDR_W-1:0] WriteRegister_q,
  output logic              DestIsZero,
  output logic [CNT_W-1:0]  RdSelCount
);
  logic [ADDR_W-1:0] sel, wr_d, wr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  always_comb begin
    sel   = RegDst ? rd : rt;
`ifdef REGDST_LINK_EN
    wr_d  = Link ? ADDR_W'(LINK_REG) : sel;
`else
    wr_d  = sel;
`endif
    // counts RegDst cycles even when Link overrides the selection
    cnt_d = (RegDst && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign WriteRegister   = wr_d;
  assign DestIsZero      = (wr_d == '0);
  assign WriteRegister_q = wr_q;
  assign RdSelCount      = cnt_q;
endmodule

// File: tb/tb_regdst_mux.sv
// tb_regdst_mux: directed self-checking bench; a second instance with CNT_W=4 exercises saturation
module tb_regdst_mux;
  logic clk = 0, reset = 1, RegDst = 0;
  logic [4:0] rt = 0, rd = 0;
  logic [4:0] wr, wr_q, wr_s, wr_q_s;
  logic dz, dz_s;
  logic [15:0] cnt;
  logic [3:0] cnt_s;
  int n_cmp = 0, n_err = 0;
`ifdef REGDST_LINK_EN
  logic Link = 0;
`endif

  always #5 clk = ~clk;

  regdst_mux dut (
    .clk(clk), .reset(reset), .rt(rt), .rd(rd), .RegDst(RegDst),
`ifdef REGDST_LINK_EN
    .Link(Link),
`endif
    .WriteRegister(wr), .WriteRegister_q(wr_q), .DestIsZero(dz), .RdSelCount(cnt)
  );

  regdst_mux #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .rt(rt), .rd(rd), .RegDst(RegDst),
`ifdef REGDST_LINK_EN
    .Link(Link),
`endif
    .WriteRegister(wr_s), .WriteRegister_q(wr_q_s), .DestIsZero(dz_s), .RdSelCount(cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rt = 5'd9; rd = 5'd5; RegDst = 1; reset = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    rd = 5'd17;
    tick();
    n_cmp++; if (wr_q !== 5'd0) begin n_err++; $display("FAIL reset_wrq got %0d exp 0", wr_q); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    n_cmp++; if (cnt_s !== 4'd0) begin n_err++; $display("FAIL reset_cnt_s got %0d exp 0", cnt_s); end
    n_cmp++; if (wr !== 5'd17) begin n_err++; $display("FAIL reset_wr_tracks got %0d exp 17", wr); end
    RegDst = 0;
    #1;
    n_cmp++; if (wr !== 5'd9) begin n_err++; $display("FAIL reset_wr_rt got %0d exp 9", wr); end
    reset = 0;
  endtask

  task automatic test_select();
    rt = 5'b10101; rd = 5'b11011; RegDst = 0;
    #10;
    n_cmp++; if (wr !== 5'b10101) begin n_err++; $display("FAIL sel_rt0 got %b exp 10101", wr); end
    RegDst = 1; #10;
    n_cmp++; if (wr !== 5'b11011) begin n_err++; $display("FAIL sel_rd0 got %b exp 11011", wr); end
    RegDst = 0; #10;
    n_cmp++; if (wr !== 5'b10101) begin n_err++; $display("FAIL sel_rt1 got %b exp 10101", wr); end
    RegDst = 1; #10;
    n_cmp++; if (wr !== 5'b11011) begin n_err++; $display("FAIL sel_rd1 got %b exp 11011", wr); end
  endtask

  task automatic test_zero_and_reg();
    tick();
    rt = 5'b00000; rd = 5'b00111; RegDst = 0;
    #1;
    n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_one got %b exp 1", dz); end
    n_cmp++; if (wr_q !== 5'b11011) begin n_err++; $display("FAIL wrq_prev got %b exp 11011", wr_q); end
    tick();
    n_cmp++; if (wr_q !== 5'd0) begin n_err++; $display("FAIL wrq_zero got %0d exp 0", wr_q); end
    RegDst = 1;
    #1;
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL dz_zero got %b exp 0", dz); end
    n_cmp++; if (wr_q !== 5'd0) begin n_err++; $display("FAIL wrq_hold got %0d exp 0", wr_q); end
    tick();
    n_cmp++; if (wr_q !== 5'd7) begin n_err++; $display("FAIL wrq_seven got %0d exp 7", wr_q); end
  endtask

  task automatic test_count();
    reset = 1; tick(); reset = 0;
    RegDst = 1; repeat (5) tick();
    RegDst = 0; repeat (3) tick();
    n_cmp++; if (cnt !== 16'd5) begin n_err++; $display("FAIL count5 got %0d exp 5", cnt); end
    n_cmp++; if (cnt_s !== 4'd5) begin n_err++; $display("FAIL count5_s got %0d exp 5", cnt_s); end
  endtask

  task automatic test_saturate();
    reset = 1; tick(); reset = 0;
    RegDst = 1; repeat (14) tick();
    n_cmp++; if (cnt_s !== 4'd14) begin n_err++; $display("FAIL sat_pre got %0d exp 14", cnt_s); end
    repeat (6) tick();
    n_cmp++; if (cnt_s !== 4'd15) begin n_err++; $display("FAIL sat_hold got %0d exp 15", cnt_s); end
    n_cmp++; if (cnt !== 16'd20) begin n_err++; $display("FAIL wide_count got %0d exp 20", cnt); end
    RegDst = 0;
  endtask

  task automatic test_reset_priority();
    RegDst = 1; reset = 1; tick();
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rst_prio got %0d exp 0", cnt); end
    reset = 0; tick();
    n_cmp++; if (cnt !== 16'd1) begin n_err++; $display("FAIL rst_release got %0d exp 1", cnt); end
    RegDst = 0;
  endtask

`ifdef REGDST_LINK_EN
  task automatic test_link();
    rt = 5'b00011; rd = 5'b00000; RegDst = 0; Link = 1;
    #1;
    n_cmp++; if (wr !== 5'b11111) begin n_err++; $display("FAIL link_wr got %b exp 11111", wr); end
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL link_dz got %b exp 0", dz); end
    RegDst = 1; #1;
    n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL link_dz_rd0 got %b exp 0", dz); end
    tick();
    n_cmp++; if (wr_q !== 5'b11111) begin n_err++; $display("FAIL link_wrq got %b exp 11111", wr_q); end
    Link = 0; RegDst = 0; #1;
    n_cmp++; if (wr !== 5'b00011) begin n_err++; $display("FAIL unlink_wr got %b exp 00011", wr); end
  endtask
`endif

  initial begin
    repeat (2) tick();
    n_cmp++; if (wr_q !== 5'd0) begin n_err++; $display("FAIL init_wrq got %0d exp 0", wr_q); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL init_cnt got %0d exp 0", cnt); end
    reset = 0;
    test_select();
    test_zero_and_reg();
    test_reset();
    test_count();
    test_saturate();
    test_reset_priority();
`ifdef REGDST_LINK_EN
    test_link();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
